// File: rtl/portc_seg_display_pkg.sv
// rtl/portc_seg_display_pkg.sv - shared constants, FSM state type and helpers for the port C display
package portc_seg_display_pkg;

    localparam int NDIG = 5;
    localparam int NAN  = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every BCD nibble before each shift
    function automatic logic [19:0] bcd_adjust(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < NDIG; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/portc_seg_display_if.sv
// rtl/portc_seg_display_if.sv - value input and display outputs of the port C display stage
interface portc_seg_display_if;
    logic [15:0] value;
    logic        busy;
    logic [19:0] bcd;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value,
        input  busy, bcd, an, seg, dp
    );

    modport slave (
        input  value,
        output busy, bcd, an, seg, dp
    );
endinterface

// File: rtl/portc_seg_display_bin2bcd_seq.sv
// rtl/portc_seg_display_bin2bcd_seq.sv - 16-cycle shift-add-3 binary to 5-digit BCD converter
module bin2bcd_seq
    import portc_seg_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    output logic        busy,
    output logic [19:0] bcd
);

    conv_state_t state;
    logic [15:0] bin;
    logic [15:0] last_value;
    logic [19:0] scratch;
    logic [3:0]  cnt;
    logic [19:0] adj;
    logic [19:0] next_scratch;

    assign adj          = bcd_adjust(scratch);
    assign next_scratch = {adj[18:0], bin[15]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            bcd        <= '0;
            bin        <= '0;
            last_value <= '0;
            scratch    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (value != last_value) begin
                        bin        <= value;
                        last_value <= value;
                        scratch    <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= next_scratch;
                    bin     <= {bin[14:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                    // bcd only moves on the last shift so readers never see a partial result
                    if (cnt == 4'd15) begin
                        bcd   <= next_scratch;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/portc_seg_display.sv
// rtl/portc_seg_display.sv - port C value to multiplexed 8-digit 7-segment display
module portc_seg_display
    import portc_seg_display_pkg::*;
#(
    parameter int SCAN_W   = 18,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    portc_seg_display_if.slave bus
);

    localparam logic [SCAN_W-1:0] SCAN_ONE = 1;

    logic [19:0]       bcd;
    logic              busy;
    logic [SCAN_W-1:0] refresh;
    logic [2:0]        k;
    logic [NDIG-1:0]   zero_from;
    logic [3:0]        digit;
    logic [NAN-1:0]    next_an;
    logic [6:0]        next_seg;
    logic [NAN-1:0]    an_q;
    logic [6:0]        seg_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .value (bus.value),
        .busy  (busy),
        .bcd   (bcd)
    );

    assign bus.busy = busy;
    assign bus.bcd  = bcd;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;

    assign k = refresh[SCAN_W-1 -: 3];

    // zero_from[i] is set when digits i..4 are all zero
    always_comb begin
        zero_from = '0;
        zero_from[NDIG-1] = (bcd[19:16] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (bcd[i*4 +: 4] == 4'd0);
        end
    end

    always_comb begin
        next_an  = '1;
        next_seg = SEG_BLANK;
        digit    = 4'd0;
        if (k < 3'(NDIG)) begin
            digit = bcd[{k, 2'b00} +: 4];
            if (!(BLANK_LZ && (k != 3'd0) && zero_from[k])) begin
                next_an  = ~(8'd1 << k);
                next_seg = seg_decode(digit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            refresh <= refresh + SCAN_ONE;
            an_q    <= next_an;
            seg_q   <= next_seg;
        end
    end

endmodule

// File: tb/tb_portc_seg_display.sv
// tb/tb_portc_seg_display.sv - self-checking bench for portc_seg_display
module tb_portc_seg_display;

    typedef struct {
        logic [15:0]      value;
        logic [19:0]      bcd;
        logic [7:0][7:0]  an;
        logic [7:0][6:0]  seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   tb_cnt;
    vec_t vecs[6];

    always #5 clk = ~clk;

    portc_seg_display_if if0 ();
    portc_seg_display_if if1 ();

    portc_seg_display #(.SCAN_W(6), .BLANK_LZ(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    portc_seg_display #(.SCAN_W(6), .BLANK_LZ(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= tb_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_value(input logic [15:0] v);
        if0.value = v;
        if1.value = v;
    endtask

    task automatic run_conv(input string name, input logic [19:0] exp_bcd);
        int          n = 0;
        int          busy_cnt = 0;
        bit          stable = 1'b1;
        logic [19:0] old;
        old = if0.bcd;
        while (!if0.busy && n < 4) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start"}, 32'(if0.busy), 32'd1);
        while (if0.busy && busy_cnt < 40) begin
            if (if0.bcd !== old) stable = 1'b0;
            busy_cnt++;
            @(negedge clk);
        end
        check({name, "_busy_len"}, busy_cnt, 32'd16);
        check({name, "_stable"}, 32'(stable), 32'd1);
        check({name, "_bcd"}, 32'(if0.bcd), 32'(exp_bcd));
        check({name, "_bcd_nolz"}, 32'(if1.bcd), 32'(exp_bcd));
    endtask

    task automatic check_scan(input bit sel, input string name,
                              input logic [7:0][7:0] an_exp, input logic [7:0][6:0] seg_exp);
        logic [7:0][7:0] an_got;
        logic [7:0][6:0] seg_got;
        logic [7:0]      seen;
        seen    = '0;
        an_got  = '0;
        seg_got = '0;
        for (int i = 0; i < 80 && seen != 8'hFF; i++) begin
            @(negedge clk);
            if (tb_cnt >= 1 && ((tb_cnt - 1) % 8) == 4) begin
                int s;
                s = ((tb_cnt - 1) % 64) / 8;
                an_got[s]  = sel ? if1.an  : if0.an;
                seg_got[s] = sel ? if1.seg : if0.seg;
                seen[s]    = 1'b1;
            end
        end
        check({name, "_slots_seen"}, 32'(seen), 32'hFF);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_an%0d", name, k), 32'(an_got[k]), 32'(an_exp[k]));
            if (an_exp[k] != 8'hFF || k >= 5)
                check($sformatf("%s_seg%0d", name, k), 32'(seg_got[k]), 32'(seg_exp[k]));
        end
        check({name, "_dp"}, 32'(sel ? if1.dp : if0.dp), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit          saw_busy;
        int          cnt;

        vecs[0] = '{16'd4660,  20'h04660, 64'hFFFF_FFFF_F7FB_FDFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h02, 7'h02, 7'h40}};
        vecs[1] = '{16'd65535, 20'h65535, 64'hFFFF_FFEF_F7FB_FDFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
        vecs[2] = '{16'd9,     20'h00009, 64'hFFFF_FFFF_FFFF_FFFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}};
        vecs[3] = '{16'd10000, 20'h10000, 64'hFFFF_FFEF_F7FB_FDFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'd807,   20'h00807, 64'hFFFF_FFFF_FFFB_FDFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h40, 7'h78}};
        vecs[5] = '{16'd0,     20'h00000, 64'hFFFF_FFFF_FFFF_FFFE,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};

        // Reset state
        rst_n = 1'b0;
        set_value(16'd0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_bcd",  32'(if0.bcd),  32'd0);
        check("rst_an",   32'(if0.an),   32'hFF);
        check("rst_seg",  32'(if0.seg),  32'h7F);
        check("rst_dp",   32'(if0.dp),   32'd1);
        rst_n = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.busy) saw_busy = 1'b1;
        end
        check("rst_no_conv", 32'(saw_busy), 32'd0);
        check_scan(1'b0, "rst_scan", vecs[5].an, vecs[5].seg);

        // Table-driven conversions and scan patterns
        for (int v = 0; v < 6; v++) begin
            set_value(vecs[v].value);
            run_conv($sformatf("vec%0d", v), vecs[v].bcd);
            check_scan(1'b0, $sformatf("vec%0d_scan", v), vecs[v].an, vecs[v].seg);
        end

        // Value changes from 5 to 7 during the 8th SHIFT cycle
        set_value(16'd5);
        @(negedge clk);
        cnt = 0;
        while (if0.busy && cnt < 8) begin
            cnt++;
            if (cnt < 8) @(negedge clk);
        end
        set_value(16'd7);
        while (if0.busy && cnt < 40) begin
            @(negedge clk);
            if (if0.busy) cnt++;
        end
        check("chg_first_len", cnt, 32'd16);
        check("chg_first_bcd", 32'(if0.bcd), 32'h00005);
        check("chg_idle_gap",  32'(if0.busy), 32'd0);
        @(negedge clk);
        check("chg_restart", 32'(if0.busy), 32'd1);
        cnt = 0;
        while (if0.busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("chg_second_len", cnt, 32'd16);
        check("chg_second_bcd", 32'(if0.bcd), 32'h00007);

        // Leading zeros shown when blanking is disabled
        check_scan(1'b1, "nolz_scan", 64'hFFFF_FFEF_F7FB_FDFE,
                   {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78});
        check_scan(1'b0, "lz7_scan", 64'hFFFF_FFFF_FFFF_FFFE,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});

        // Reset during SHIFT cycle 10, then reconversion
        set_value(16'd999);
        @(negedge clk);
        cnt = 1;
        while (if0.busy && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_rst_in_shift", 32'(if0.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd",  32'(if0.bcd),  32'd0);
        check("mid_rst_busy", 32'(if0.busy), 32'd0);
        check("mid_rst_an",   32'(if0.an),   32'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_conv("mid_rst_reconv", 20'h00999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/portc_seg_display.md
Name: portc_seg_display

Overview:
- Display stage directly downstream of the memory-mapped IO block: consumes the 16-bit port C output register and drives the board's 8-digit multiplexed 7-segment display.
- Converts the unsigned binary value to 5 BCD digits with a sequential shift-add-3 converter (16 cycles).
- Time-multiplexes the digits onto the shared segment lines.
- Software updates the display by storing to the port C address; this block needs no bus interface.

Parameters:
- SCAN_W, 18, refresh counter width; each digit is lit for 2^(SCAN_W-3) clocks.
- BLANK_LZ, 1, when 1, leading-zero digits are blanked (digit 0 is always shown).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- value  input  16  unsigned binary value, connected to portc_out
- busy  output  1  high while a conversion is in progress
- bcd  output  20  latched BCD digits {d4,d3,d2,d1,d0}, d0 = units
- an  output  8  digit enables, active-low, an[0] = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low, held 1 (off)

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, bcd=0, last_value=0, refresh counter=0, an=8'hFF, seg=7'h7F, dp=1. Because last_value resets to 0, value=0 out of reset triggers no conversion.
- Converter FSM has two states, IDLE and SHIFT:
  - IDLE: when value != last_value at edge E0, capture bin=value and last_value=value, clear the 20-bit scratch register, set cnt=0, go to SHIFT, and set busy=1.
  - SHIFT: at each edge, first add 3 to every scratch nibble >= 5, then shift {scratch,bin} left by 1 and increment cnt.
  - Edges E1..E16 perform the 16 shifts. At E16, load bcd from the final scratch value, set busy=0 and return to IDLE.
  - Latency is 16 clocks from the capture edge to the bcd update.
  - The bcd value is stable between updates; it is never partially updated.
- value changes during SHIFT are ignored for the current conversion. The first IDLE cycle compares value against last_value again, so the final value is always converted. Back-to-back conversions have exactly one IDLE cycle between them.
- Arithmetic: the maximum input, 65535, yields d4=6; nibbles never exceed 9 after conversion. No overflow path exists.
- Scan:
  - The refresh counter is free-running and wraps at 2^SCAN_W.
  - Digit index k = counter[SCAN_W-1:SCAN_W-3], covering 0..7.
  - an and seg are registered, one cycle behind k.
  - For k in 0..4: an = ~(1<<k), seg = decode(d_k).
  - For k in 5..7: an = 8'hFF and seg = 7'h7F (digit dark).
  - Blanking: when BLANK_LZ=1 and k >= 1, digit k is dark (an all ones) if d_k..d4 are all zero.
  - Scan is independent of the converter and continues while busy=1, showing the old bcd.
- Decode is active-low, bit order gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes A-F map to 7F (blank) and are unreachable.
- Reset mid-conversion: the conversion is abandoned and bcd=0. After release, a nonzero value reconverts because last_value=0.

Decomposition:
- Shared package holds:
  - the segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - the digit count constant NDIG=5;
  - the display width constant NAN=8.
- One sub-module, bin2bcd_seq: clk, rst_n, value, busy, bcd. It contains the converter FSM and last_value, and is reusable for the port B input path.
- Scan counter, blanking and decode stay in the top module.

Test Plan (bench uses SCAN_W=6, so each digit is lit for 8 clocks):
- Reset with value=0 -> busy stays 0; bcd=0; during k=0 an=FE and seg=40; all other slots an=FF (BLANK_LZ=1).
- value=16'h1234 (4660) -> busy is high for exactly 16 clocks; bcd=20'h04660; scan shows 0/6/6/4 on an FE/FD/FB/F7 with seg 40/02/02/19; k=4 is dark.
- value=16'hFFFF -> bcd=20'h65535; slots 0..4 show seg 12,30,12,12,02.
- Change value 5 -> 7 at the 8th SHIFT cycle of a 0 -> 5 conversion -> bcd=5 after the first conversion, one IDLE cycle, then bcd=7 16 clocks later.
- value=7 with BLANK_LZ=0 -> an cycles FE..EF with seg 78,40,40,40,40; slots 5..7 are dark.
- Assert rst_n at SHIFT cycle 10 with value=999, release -> bcd=0, then reconversion gives bcd=20'h00999.
